water_dispenser_multi_tap: RTL and testbench

Parametrised successor to the single-output water_dispenser. Accumulates a requested volume from a one-hot-style switch bank and debounce-free push buttons. On confirmation, it dispenses that volume on one of TAP_COUNT taps by holding that tap's valve open for a timed number of cycles. Sits between the board I/O (switches/buttons) and the valve drivers / seven-segment display logic.

---
 rtl/water_dispenser_multi_tap_pkg.sv | 18 +
 rtl/button_edge_detector.sv | 23 ++
 rtl/water_dispenser_multi_tap.sv | 136 +++++++++++++
 tb/tb_water_dispenser_multi_tap.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/water_dispenser_multi_tap_pkg.sv
// Shared state encodings and default constants for the water dispenser family.
package water_dispenser_multi_tap_pkg;

   localparam logic [0:0] STATE_IDLE     = 1'b0;
   localparam logic [0:0] STATE_DISPENSE = 1'b1;

   localparam int unsigned DEF_SWITCH_COUNT   = 10;
   localparam int unsigned DEF_TAP_COUNT      = 2;
   localparam int unsigned DEF_AMOUNT_WIDTH   = 8;
   localparam int unsigned DEF_MAX_AMOUNT     = 200;
   localparam int unsigned DEF_TICKS_PER_UNIT = 4;

   // Index width for a set of n items, never narrower than one bit.
   function automatic int unsigned idx_width(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_edge_detector.sv
// Registers each button level once and pulses on its rising edge.
module button_edge_detector #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] btn_i,
   output logic [WIDTH-1:0] rise_o
);

   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q <= '0;
      end else begin
         prev_q <= btn_i;
      end
   end

   assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/water_dispenser_multi_tap.sv
// Accumulates a requested volume from switches/buttons and dispenses it on one of several taps
// by holding that tap's valve open for amount * TICKS_PER_UNIT cycles.
module water_dispenser_multi_tap
   import water_dispenser_multi_tap_pkg::*;
#(
   parameter int unsigned SWITCH_COUNT   = DEF_SWITCH_COUNT,
   parameter int unsigned TAP_COUNT      = DEF_TAP_COUNT,
   parameter int unsigned AMOUNT_WIDTH   = DEF_AMOUNT_WIDTH,
   parameter int unsigned MAX_AMOUNT     = DEF_MAX_AMOUNT,
   parameter int unsigned TICKS_PER_UNIT = DEF_TICKS_PER_UNIT
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [SWITCH_COUNT-1:0]             switches,
   input  logic [idx_width(TAP_COUNT)-1:0]     tap_select,
   input  logic                                button_add,
   input  logic                                button_ok,
   input  logic                                button_cancel,
   output logic [AMOUNT_WIDTH-1:0]             total_amount,
   output logic [TAP_COUNT-1:0]                valve_open,
   output logic                                busy,
   output logic                                overflow,
   output logic                                done
);

   localparam int unsigned TapW  = idx_width(TAP_COUNT);
   localparam int unsigned TickW = idx_width(TICKS_PER_UNIT);

   logic [2:0]              btn_ev;
   logic                    add_ev, ok_ev, cancel_ev;
   logic [AMOUNT_WIDTH-1:0] amount;
   logic [AMOUNT_WIDTH:0]   sum;

   logic [0:0]              state_q, state_d;
   logic [AMOUNT_WIDTH-1:0] total_q, total_d;
   logic                    ovf_q, ovf_d;
   logic                    done_q, done_d;
   logic [TapW-1:0]         tap_q, tap_d;
   logic [TickW-1:0]        tick_q, tick_d;

   button_edge_detector #(
      .WIDTH(3)
   ) u_buttons (
      .clock (clock),
      .reset (reset),
      .btn_i ({button_cancel, button_ok, button_add}),
      .rise_o(btn_ev)
   );

   assign add_ev    = btn_ev[0];
   assign ok_ev     = btn_ev[1];
   assign cancel_ev = btn_ev[2];

   // Highest set switch wins; later iterations override earlier ones.
   always_comb begin
      amount = '0;
      for (int i = 0; i < int'(SWITCH_COUNT); i++) begin
         if (switches[i]) amount = AMOUNT_WIDTH'(i);
      end
   end

   assign sum = {1'b0, total_q} + {1'b0, amount};

   always_comb begin
      state_d = state_q;
      total_d = total_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      tap_d   = tap_q;
      tick_d  = tick_q;
      if (state_q == STATE_IDLE) begin
         if (cancel_ev) begin
            total_d = '0;
            ovf_d   = 1'b0;
         end else if (ok_ev && (total_q != '0) && (32'(tap_select) < TAP_COUNT)) begin
            tap_d   = tap_select;
            tick_d  = '0;
            state_d = STATE_DISPENSE;
         end else if (add_ev) begin
            if (sum > (AMOUNT_WIDTH + 1)'(MAX_AMOUNT)) begin
               total_d = AMOUNT_WIDTH'(MAX_AMOUNT);
               ovf_d   = 1'b1;
            end else begin
               total_d = sum[AMOUNT_WIDTH-1:0];
            end
         end
      end else begin
         if (cancel_ev) begin
            total_d = '0;
            ovf_d   = 1'b0;
            state_d = STATE_IDLE;
         end else if (tick_q == TickW'(TICKS_PER_UNIT - 1)) begin
            tick_d  = '0;
            total_d = total_q - AMOUNT_WIDTH'(1);
            if (total_q == AMOUNT_WIDTH'(1)) begin
               done_d  = 1'b1;
               ovf_d   = 1'b0;
               state_d = STATE_IDLE;
            end
         end else begin
            tick_d = tick_q + TickW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= STATE_IDLE;
         total_q <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         tap_q   <= '0;
         tick_q  <= '0;
      end else begin
         state_q <= state_d;
         total_q <= total_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         tap_q   <= tap_d;
         tick_q  <= tick_d;
      end
   end

   always_comb begin
      valve_open = '0;
      for (int i = 0; i < int'(TAP_COUNT); i++) begin
         valve_open[i] = (state_q == STATE_DISPENSE) && (32'(tap_q) == 32'(i));
      end
   end

   assign busy         = (state_q == STATE_DISPENSE);
   assign total_amount = total_q;
   assign overflow     = ovf_q;
   assign done         = done_q;

endmodule

// File: tb/tb_water_dispenser_multi_tap.sv
// Scoreboard bench: expected per-cycle outputs are queued with the stimulus and compared
// against the DUT one cycle at a time, sampled 1 time unit after each rising edge.
module tb_water_dispenser_multi_tap;

   localparam int TAPS  = 3;
   localparam int TICKS = 4;
   localparam int MAXV  = 200;

   logic       clock;
   logic       reset;
   logic [9:0] switches;
   logic [1:0] tap_select;
   logic       button_add, button_ok, button_cancel;
   logic [7:0] total_amount;
   logic [2:0] valve_open;
   logic       busy, overflow, done;

   int checks = 0;
   int errors = 0;
   int model_total = 0;
   int model_ovf = 0;

   typedef struct {
      string tag;
      int    total;
      int    valve;
      int    busy;
      int    ovf;
      int    done;
   } exp_t;

   exp_t sb[$];

   water_dispenser_multi_tap #(
      .SWITCH_COUNT  (10),
      .TAP_COUNT     (TAPS),
      .AMOUNT_WIDTH  (8),
      .MAX_AMOUNT    (MAXV),
      .TICKS_PER_UNIT(TICKS)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .switches     (switches),
      .tap_select   (tap_select),
      .button_add   (button_add),
      .button_ok    (button_ok),
      .button_cancel(button_cancel),
      .total_amount (total_amount),
      .valve_open   (valve_open),
      .busy         (busy),
      .overflow     (overflow),
      .done         (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input string tag, input int total, input int valve, input int bz,
                           input int ovf, input int dn);
      exp_t e;
      e.tag = tag; e.total = total; e.valve = valve; e.busy = bz; e.ovf = ovf; e.done = dn;
      sb.push_back(e);
   endtask

   task automatic pop_cmp();
      exp_t e;
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.tag, "_total"}, 32'(total_amount), 32'(e.total));
         check({e.tag, "_valve"}, 32'(valve_open), 32'(e.valve));
         check({e.tag, "_busy"}, 32'(busy), 32'(e.busy));
         check({e.tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
         check({e.tag, "_done"}, 32'(done), 32'(e.done));
      end
   endtask

   function automatic int hibit(input logic [9:0] sw);
      int r = 0;
      for (int i = 0; i < 10; i++) if (sw[i]) r = i;
      return r;
   endfunction

   // Hold add for `hold` cycles, then release for one cycle.
   task automatic add_press(input string tag, input logic [9:0] sw, input int hold);
      int s = model_total + hibit(sw);
      if (s > MAXV) begin
         model_total = MAXV;
         model_ovf = 1;
      end else begin
         model_total = s;
      end
      for (int c = 0; c <= hold; c++) push_exp(tag, model_total, 0, 0, model_ovf, 0);
      switches = sw;
      button_add = 1'b1;
      for (int c = 0; c < hold; c++) begin
         tick();
         pop_cmp();
      end
      button_add = 1'b0;
      tick();
      pop_cmp();
   endtask

   task automatic cancel_press(input string tag);
      model_total = 0;
      model_ovf = 0;
      push_exp(tag, 0, 0, 0, 0, 0);
      push_exp(tag, 0, 0, 0, 0, 0);
      button_cancel = 1'b1;
      tick();
      pop_cmp();
      button_cancel = 1'b0;
      tick();
      pop_cmp();
   endtask

   // Ok press expected to be ignored: outputs hold the idle model for two cycles.
   task automatic ok_ignored(input string tag, input logic [1:0] tap);
      push_exp(tag, model_total, 0, 0, model_ovf, 0);
      push_exp(tag, model_total, 0, 0, model_ovf, 0);
      tap_select = tap;
      button_ok = 1'b1;
      tick();
      pop_cmp();
      button_ok = 1'b0;
      tick();
      pop_cmp();
   endtask

   initial begin
      reset = 1'b1;
      switches = '0;
      tap_select = '0;
      button_add = 1'b1;
      button_ok = 1'b1;
      button_cancel = 1'b1;

      // Reset with all buttons held, then release with them still held.
      for (int c = 0; c < 5; c++) push_exp("reset", 0, 0, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         pop_cmp();
      end
      reset = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         pop_cmp();
      end
      button_add = 1'b0;
      button_ok = 1'b0;
      button_cancel = 1'b0;
      tick();

      // Accumulate; held presses count once.
      add_press("acc1", 10'h002, 5);
      add_press("acc10", 10'h200, 3);
      add_press("acc19", 10'h200, 3);
      add_press("acc22", 10'h008, 1);
      add_press("acc_multi", 10'h228, 1);
      check("acc_model31", 32'(model_total), 32'd31);
      add_press("add_zero", 10'h000, 1);

      // Saturation.
      cancel_press("clr");
      for (int k = 0; k < 22; k++) add_press("sat", 10'h200, 1);
      check("sat_198", 32'(total_amount), 32'd198);
      add_press("sat_clip", 10'h200, 1);
      add_press("sat_hold", 10'h200, 1);
      cancel_press("sat_cancel");

      // Full dispense of 3 units on tap 1; add mid-dispense and tap change are ignored.
      add_press("d_load", 10'h008, 1);
      for (int c = 0; c < 3 * TICKS; c++) push_exp("disp", 3 - c / TICKS, 3'b010, 1, 0, 0);
      push_exp("disp_done", 0, 0, 0, 0, 1);
      push_exp("disp_after", 0, 0, 0, 0, 0);
      for (int c = 0; c < 3 * TICKS + 2; c++) begin
         tap_select = (c < 5) ? 2'd1 : 2'd0;
         button_ok  = (c == 0);
         button_add = (c == 5 || c == 6);
         switches   = (c >= 5) ? 10'h200 : 10'h008;
         tick();
         pop_cmp();
      end
      model_total = 0;

      // Abort 5 cycles into a dispense on tap 2.
      add_press("a_load", 10'h008, 1);
      for (int c = 0; c < 5; c++) push_exp("abort_run", (c < TICKS) ? 3 : 2, 3'b100, 1, 0, 0);
      push_exp("abort_edge", 0, 0, 0, 0, 0);
      push_exp("abort_nodone", 0, 0, 0, 0, 0);
      tap_select = 2'd2;
      for (int c = 0; c < 7; c++) begin
         button_ok     = (c == 0);
         button_cancel = (c == 5);
         tick();
         pop_cmp();
      end
      button_cancel = 1'b0;
      model_total = 0;
      ok_ignored("ok_zero", 2'd1);
      add_press("bad_load", 10'h008, 1);
      ok_ignored("ok_badtap", 2'd3);
      cancel_press("bad_clr");

      // Ok with cancel on the same cycle.
      add_press("s_load", 10'h020, 1);
      push_exp("okcancel", 0, 0, 0, 0, 0);
      push_exp("okcancel", 0, 0, 0, 0, 0);
      button_ok = 1'b1;
      button_cancel = 1'b1;
      tick();
      pop_cmp();
      button_ok = 1'b0;
      button_cancel = 1'b0;
      tick();
      pop_cmp();
      model_total = 0;

      // Ok with add: pre-add amount dispensed on tap 0, then reset mid-dispense.
      add_press("s_load2", 10'h020, 1);
      for (int c = 0; c < 3; c++) push_exp("okadd", 5, 3'b001, 1, 0, 0);
      push_exp("rst_mid", 0, 0, 0, 0, 0);
      push_exp("rst_after", 0, 0, 0, 0, 0);
      tap_select = 2'd0;
      switches = 10'h010;
      for (int c = 0; c < 5; c++) begin
         button_ok  = (c == 0);
         button_add = (c == 0);
         reset      = (c == 3);
         tick();
         pop_cmp();
      end
      reset = 1'b0;

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
